// File: rtl/m68k_bus_uart_slave_if.sv
// 68000 asynchronous bus pins as seen by the target; master drives strobes/address.
interface m68k_bus_uart_slave_if;
  logic [22:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_oe;
  logic        ASn;
  logic        R_Wn;
  logic        UDSn;
  logic        LDSn;
  logic        DTACKn;

  modport master (
    output addr, data_in, ASn, R_Wn, UDSn, LDSn,
    input  data_out, data_oe, DTACKn
  );

  modport slave (
    input  addr, data_in, ASn, R_Wn, UDSn, LDSn,
    output data_out, data_oe, DTACKn
  );
endinterface

// File: rtl/m68k_bus_uart_slave.sv
// 68000 bus target: word RAM with byte lanes plus a 4-word UART register window
// backed by RX/TX byte FIFOs feeding external UART_RX/UART_TX cores.
module m68k_bus_uart_slave #(
  parameter int unsigned MEM_AW      = 12,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned FIFO_AW     = 4,
  parameter logic [22:0] UART_BASE   = 23'h03c000,
  parameter              INIT_FILE   = ""
) (
  input  logic                        clk12,
  input  logic                        rst,
  m68k_bus_uart_slave_if.slave        bus,
  output logic                        tx_dv,
  output logic [7:0]                  tx_data,
  input  logic                        tx_active,
  input  logic                        rx_dv,
  input  logic [7:0]                  rx_byte,
  output logic                        irq_n
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_ACK} state_t;

  // ---------------- strobe synchronisers ----------------
  logic [1:0] as_sy, rw_sy, uds_sy, lds_sy;
  logic       as_s, rw_s, uds_s, lds_s;

  always_ff @(posedge clk12) begin
    if (rst) begin
      as_sy  <= '1;
      rw_sy  <= '1;
      uds_sy <= '1;
      lds_sy <= '1;
    end else begin
      as_sy  <= {as_sy[0],  bus.ASn};
      rw_sy  <= {rw_sy[0],  bus.R_Wn};
      uds_sy <= {uds_sy[0], bus.UDSn};
      lds_sy <= {lds_sy[0], bus.LDSn};
    end
  end

  assign as_s  = as_sy[1];
  assign rw_s  = rw_sy[1];
  assign uds_s = uds_sy[1];
  assign lds_s = lds_sy[1];

  // ---------------- latched cycle and decode ----------------
  state_t      state;
  logic [22:0] a_q;
  logic        rw_q, uds_q, lds_q;
  logic [3:0]  ws_cnt;

  logic [22:0]       off;
  logic              in_win, acc;
  logic              sel_rx, sel_tx, sel_stat;
  logic [MEM_AW-1:0] ram_idx;

  assign off      = a_q - UART_BASE;
  assign in_win   = (off < 23'd4);
  assign sel_rx   = in_win && (off[1:0] == 2'd0);
  assign sel_tx   = in_win && (off[1:0] == 2'd1);
  assign sel_stat = in_win && (off[1:0] == 2'd2);
  assign acc      = (state == S_ACCESS) && !rst;
  assign ram_idx  = a_q[MEM_AW-1:0];

  // ---------------- FIFO state ----------------
  logic [7:0]         rx_mem [DEPTH];
  logic [FIFO_AW-1:0] rx_wp, rx_rp;
  logic [CW-1:0]      rx_cnt;
  logic               rx_full, rx_empty, rx_push, rx_pop, rx_ovf_set;

  logic [7:0]         tx_mem [DEPTH];
  logic [FIFO_AW-1:0] tx_wp, tx_rp;
  logic [CW-1:0]      tx_cnt;
  logic               tx_full, tx_empty, tx_req, tx_push, tx_pop, tx_drop_set;
  logic [7:0]         tx_byte_in;
  logic [1:0]         hold;

  logic rx_overrun, tx_drop, stat_rd, ram_we;
  logic [3:0]  rx_cnt_sat;
  logic [15:0] status, rd_mux;

  assign rx_full    = (rx_cnt == CW'(DEPTH));
  assign rx_empty   = (rx_cnt == '0);
  assign rx_pop     = acc && rw_q && sel_rx && !rx_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign rx_push    = rx_dv && (!rx_full || rx_pop);
  assign rx_ovf_set = rx_dv && rx_full && !rx_pop;

  assign tx_full     = (tx_cnt == CW'(DEPTH));
  assign tx_empty    = (tx_cnt == '0);
  assign tx_req      = acc && !rw_q && sel_tx;
  assign tx_push     = tx_req && !tx_full;
  assign tx_drop_set = tx_req && tx_full;
  assign tx_byte_in  = uds_q ? bus.data_in[7:0] : bus.data_in[15:8];
  assign tx_pop      = !tx_empty && !tx_active && (hold == 2'd0);

  assign stat_rd    = acc && rw_q && sel_stat;
  assign ram_we     = acc && !rw_q && !in_win;
  assign rx_cnt_sat = (32'(rx_cnt) > 32'd15) ? 4'hF : 4'(rx_cnt);
  assign status     = {8'h00, rx_overrun, tx_drop, tx_full, rx_empty, rx_cnt_sat};

  // ---------------- RAM ----------------
  logic [15:0] mem [2**MEM_AW];

  always_ff @(posedge clk12) begin
    if (ram_we) begin
      if (!uds_q) mem[ram_idx][15:8] <= bus.data_in[15:8];
      if (!lds_q) mem[ram_idx][7:0]  <= bus.data_in[7:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    if (!in_win) begin
      rd_mux = mem[ram_idx];
    end else if (sel_rx) begin
      rd_mux = rx_empty ? 16'h0000 : {rx_mem[rx_rp], rx_mem[rx_rp]};
    end else if (sel_stat) begin
      rd_mux = status;
    end
  end

  // ---------------- bus FSM ----------------
  always_ff @(posedge clk12) begin
    if (rst) begin
      state        <= S_IDLE;
      a_q          <= '0;
      rw_q         <= 1'b1;
      uds_q        <= 1'b1;
      lds_q        <= 1'b1;
      ws_cnt       <= '0;
      bus.DTACKn   <= 1'b1;
      bus.data_oe  <= 1'b0;
      bus.data_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!as_s) begin
            a_q   <= bus.addr;
            rw_q  <= rw_s;
            uds_q <= uds_s;
            lds_q <= lds_s;
            if (WAIT_STATES > 0) begin
              ws_cnt <= WS_LOAD;
              state  <= S_WAIT;
            end else begin
              state  <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (ws_cnt == 4'd0) state  <= S_ACCESS;
          else                ws_cnt <= ws_cnt - 4'd1;
        end
        S_ACCESS: begin
          if (rw_q) bus.data_out <= rd_mux;
          bus.DTACKn  <= 1'b0;
          bus.data_oe <= rw_q;
          state       <= S_ACK;
        end
        S_ACK: begin
          if (as_s) begin
            bus.DTACKn  <= 1'b1;
            bus.data_oe <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  always_ff @(posedge clk12) begin
    if (rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wp] <= rx_byte;
        rx_wp         <= rx_wp + 1'b1;
      end
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // ---------------- TX FIFO and drain ----------------
  always_ff @(posedge clk12) begin
    if (rst) begin
      tx_wp   <= '0;
      tx_rp   <= '0;
      tx_cnt  <= '0;
      tx_dv   <= 1'b0;
      tx_data <= '0;
      hold    <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wp] <= tx_byte_in;
        tx_wp         <= tx_wp + 1'b1;
      end
      // Holdoff gives UART_TX time to raise tx_active after the start pulse.
      if (tx_pop) begin
        tx_dv   <= 1'b1;
        tx_data <= tx_mem[tx_rp];
        tx_rp   <= tx_rp + 1'b1;
        hold    <= 2'd2;
      end else begin
        tx_dv <= 1'b0;
        if (hold != 2'd0) hold <= hold - 2'd1;
      end
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
    end
  end

  // ---------------- sticky flags and interrupt ----------------
  always_ff @(posedge clk12) begin
    if (rst) begin
      rx_overrun <= 1'b0;
      tx_drop    <= 1'b0;
      irq_n      <= 1'b1;
    end else begin
      if (rx_ovf_set)   rx_overrun <= 1'b1;
      else if (stat_rd) rx_overrun <= 1'b0;
      if (tx_drop_set)  tx_drop    <= 1'b1;
      else if (stat_rd) tx_drop    <= 1'b0;
      irq_n <= (rx_cnt == '0);
    end
  end

endmodule

// File: tb/tb_m68k_bus_uart_slave.sv
// Randomised self-checking bench for m68k_bus_uart_slave with a queue/array reference model.
module tb_m68k_bus_uart_slave;

  localparam logic [22:0] BASE = 23'h03c000;
  localparam logic [22:0] A_RX = BASE;
  localparam logic [22:0] A_TX = BASE + 23'd1;
  localparam logic [22:0] A_ST = BASE + 23'd2;
  localparam logic [22:0] A_R3 = BASE + 23'd3;

  logic clk12 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk12 = ~clk12;

  logic       tx_dv, irq_n, tx_dv_ws, irq_n_ws;
  logic [7:0] tx_data, tx_data_ws;
  logic       tx_active = 1'b1;
  logic       rx_dv     = 1'b0;
  logic [7:0] rx_byte   = 8'h00;

  logic [22:0] b_addr = '0;
  logic [15:0] b_din  = '0;
  logic b_asn = 1'b1, b_rwn = 1'b1, b_udsn = 1'b1, b_ldsn = 1'b1;
  logic sel_ws = 1'b0;

  m68k_bus_uart_slave_if bus();
  m68k_bus_uart_slave_if bus_ws();

  assign bus.addr       = b_addr;
  assign bus.data_in    = b_din;
  assign bus.ASn        = sel_ws ? 1'b1 : b_asn;
  assign bus.R_Wn       = sel_ws ? 1'b1 : b_rwn;
  assign bus.UDSn       = sel_ws ? 1'b1 : b_udsn;
  assign bus.LDSn       = sel_ws ? 1'b1 : b_ldsn;
  assign bus_ws.addr    = b_addr;
  assign bus_ws.data_in = b_din;
  assign bus_ws.ASn     = sel_ws ? b_asn  : 1'b1;
  assign bus_ws.R_Wn    = sel_ws ? b_rwn  : 1'b1;
  assign bus_ws.UDSn    = sel_ws ? b_udsn : 1'b1;
  assign bus_ws.LDSn    = sel_ws ? b_ldsn : 1'b1;

  logic        obs_dtackn, obs_oe;
  logic [15:0] obs_dout;
  assign obs_dtackn = sel_ws ? bus_ws.DTACKn   : bus.DTACKn;
  assign obs_oe     = sel_ws ? bus_ws.data_oe  : bus.data_oe;
  assign obs_dout   = sel_ws ? bus_ws.data_out : bus.data_out;

  m68k_bus_uart_slave #(.MEM_AW(8), .WAIT_STATES(0), .FIFO_AW(4), .UART_BASE(BASE), .INIT_FILE("")) dut (
    .clk12(clk12), .rst(rst), .bus(bus),
    .tx_dv(tx_dv), .tx_data(tx_data), .tx_active(tx_active),
    .rx_dv(rx_dv), .rx_byte(rx_byte), .irq_n(irq_n)
  );

  m68k_bus_uart_slave #(.MEM_AW(8), .WAIT_STATES(3), .FIFO_AW(4), .UART_BASE(BASE), .INIT_FILE("")) dut_ws (
    .clk12(clk12), .rst(rst), .bus(bus_ws),
    .tx_dv(tx_dv_ws), .tx_data(tx_data_ws), .tx_active(1'b1),
    .rx_dv(1'b0), .rx_byte(8'h00), .irq_n(irq_n_ws)
  );

  int checks = 0;
  int fails  = 0;

  // reference model
  logic [15:0] ram_m  [256];
  logic [1:0]  ram_vb [256];
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  bit          m_ovr = 1'b0, m_drop = 1'b0;

  // TX pulse monitor
  logic [7:0] txlog[$];
  logic act_at_edge = 1'b0, tx_prev = 1'b0;
  int   tx_bad_active = 0, tx_double = 0;

  always @(posedge clk12) act_at_edge <= tx_active;
  always @(negedge clk12) begin
    if (tx_dv === 1'b1) begin
      txlog.push_back(tx_data);
      if (act_at_edge) tx_bad_active++;
      if (tx_prev) tx_double++;
    end
    tx_prev = (tx_dv === 1'b1);
  end

  function automatic logic [15:0] exp_status();
    int c = rxq.size();
    return {8'h00, m_ovr, m_drop, (txq.size() == 16), (c == 0), 4'(c > 15 ? 15 : c)};
  endfunction

  function automatic void model_write(input logic [22:0] a, input logic [15:0] d, input bit udsn, input bit ldsn);
    int i = int'(a) % 256;
    if (!udsn) begin ram_m[i][15:8] = d[15:8]; ram_vb[i][1] = 1'b1; end
    if (!ldsn) begin ram_m[i][7:0]  = d[7:0];  ram_vb[i][0] = 1'b1; end
  endfunction

  task automatic bus_access(input bit rw, input logic [22:0] a, input logic [15:0] d,
                            input bit udsn, input bit ldsn, output logic [15:0] rd,
                            output int lat, output logic oe_ack, output logic oe_idle);
    int n;
    @(negedge clk12);
    b_addr = a; b_din = d; b_rwn = rw; b_udsn = udsn; b_ldsn = ldsn; b_asn = 1'b0;
    lat = 0;
    do begin @(posedge clk12); lat++; @(negedge clk12); end
    while (obs_dtackn !== 1'b0 && lat < 40);
    checks++;
    if (obs_dtackn !== 1'b0) begin
      fails++;
      $display("FAIL dtack_assert addr=%h: DTACKn=%b required 0", a, obs_dtackn);
    end
    rd = obs_dout;
    oe_ack = obs_oe;
    b_asn = 1'b1; b_rwn = 1'b1; b_udsn = 1'b1; b_ldsn = 1'b1;
    n = 0;
    do begin @(posedge clk12); n++; @(negedge clk12); end
    while (obs_dtackn !== 1'b1 && n < 40);
    checks++;
    if (obs_dtackn !== 1'b1) begin
      fails++;
      $display("FAIL dtack_release addr=%h: DTACKn=%b required 1", a, obs_dtackn);
    end
    oe_idle = obs_oe;
  endtask

  task automatic rd16(input logic [22:0] a, output logic [15:0] rd);
    int l; logic x, y;
    bus_access(1'b1, a, 16'h0000, 1'b0, 1'b0, rd, l, x, y);
  endtask

  task automatic wr16(input logic [22:0] a, input logic [15:0] d, input bit udsn, input bit ldsn);
    int l; logic x, y; logic [15:0] r;
    bus_access(1'b0, a, d, udsn, ldsn, r, l, x, y);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(negedge clk12); rx_dv = 1'b1; rx_byte = b;
    @(negedge clk12); rx_dv = 1'b0;
  endtask

  // Emulates UART_TX: busy for a random span after each start pulse.
  task automatic run_uart(input int want);
    int busy = 0;
    tx_active = 1'b0;
    for (int i = 0; i < 600 && !(txlog.size() >= want && busy == 0); i++) begin
      @(negedge clk12);
      if (tx_dv === 1'b1) begin
        busy = $urandom_range(2, 6); tx_active = 1'b1;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) tx_active = 1'b0;
      end
    end
    tx_active = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] r;
    rst = 1'b1;
    repeat (3) @(posedge clk12);
    @(negedge clk12); rst = 1'b0;
    @(negedge clk12);
    checks++; if (bus.DTACKn !== 1'b1)       begin fails++; $display("FAIL reset_dtack: got %b want 1", bus.DTACKn); end
    checks++; if (bus.data_oe !== 1'b0)      begin fails++; $display("FAIL reset_oe: got %b want 0", bus.data_oe); end
    checks++; if (bus.data_out !== 16'h0000) begin fails++; $display("FAIL reset_dout: got %h want 0000", bus.data_out); end
    checks++; if (tx_dv !== 1'b0)            begin fails++; $display("FAIL reset_txdv: got %b want 0", tx_dv); end
    checks++; if (tx_data !== 8'h00)         begin fails++; $display("FAIL reset_txdata: got %h want 00", tx_data); end
    checks++; if (irq_n !== 1'b1)            begin fails++; $display("FAIL reset_irq: got %b want 1", irq_n); end
    rd16(A_ST, r);
    checks++; if (r !== exp_status()) begin fails++; $display("FAIL reset_status: got %h want %h", r, exp_status()); end
    m_ovr = 1'b0; m_drop = 1'b0;
    rd16(A_RX, r);
    checks++; if (r !== 16'h0000) begin fails++; $display("FAIL reset_rx_empty: got %h want 0000", r); end
  endtask

  task automatic test_zero_wait_read();
    logic [15:0] r; int lat; logic oa, oi;
    wr16(23'h000010, 16'hBEEF, 1'b0, 1'b0);
    model_write(23'h000010, 16'hBEEF, 1'b0, 1'b0);
    bus_access(1'b1, 23'h000010, 16'h0000, 1'b0, 1'b0, r, lat, oa, oi);
    // two synchroniser stages, then IDLE->ACCESS->ACK
    checks++; if (lat !== 4)         begin fails++; $display("FAIL zw_latency: got %0d want 4", lat); end
    checks++; if (r !== ram_m[16])   begin fails++; $display("FAIL zw_data: got %h want %h", r, ram_m[16]); end
    checks++; if (oa !== 1'b1)       begin fails++; $display("FAIL zw_oe_ack: got %b want 1", oa); end
    checks++; if (oi !== 1'b0)       begin fails++; $display("FAIL zw_oe_idle: got %b want 0", oi); end
  endtask

  task automatic test_byte_lanes();
    logic [15:0] r; int lat; logic oa, oi;
    wr16(23'h000020, 16'hFFFF, 1'b0, 1'b0); model_write(23'h000020, 16'hFFFF, 1'b0, 1'b0);
    bus_access(1'b0, 23'h000020, 16'h1234, 1'b0, 1'b1, r, lat, oa, oi);
    model_write(23'h000020, 16'h1234, 1'b0, 1'b1);
    checks++; if (oa !== 1'b0) begin fails++; $display("FAIL write_oe: got %b want 0", oa); end
    rd16(23'h000020, r);
    checks++; if (r !== 16'h12FF) begin fails++; $display("FAIL lane_upper: got %h want 12FF", r); end
    wr16(23'h000020, 16'h5678, 1'b1, 1'b0); model_write(23'h000020, 16'h5678, 1'b1, 1'b0);
    rd16(23'h000020, r);
    checks++; if (r !== ram_m[32]) begin fails++; $display("FAIL lane_lower: got %h want %h", r, ram_m[32]); end
    bus_access(1'b0, 23'h000020, 16'hABCD, 1'b1, 1'b1, r, lat, oa, oi);
    checks++; if (lat >= 40) begin fails++; $display("FAIL lane_none_ack: latency %0d want <40", lat); end
    rd16(23'h000020, r);
    checks++; if (r !== 16'h1278) begin fails++; $display("FAIL lane_none: got %h want 1278", r); end
  endtask

  task automatic test_ram_random();
    logic [22:0] addrs[$]; logic [15:0] r, m; logic [22:0] a; logic [15:0] d; bit u, l;
    for (int i = 0; i < 40; i++) begin
      a = 23'($urandom_range(0, 1023)); d = 16'($urandom);
      u = 1'($urandom); l = 1'($urandom);
      wr16(a, d, u, l); model_write(a, d, u, l); addrs.push_back(a);
    end
    for (int i = 0; i < 25; i++) begin
      a = addrs[$urandom_range(0, addrs.size() - 1)];
      a = 23'((int'(a) % 256) + 256 * $urandom_range(0, 3));
      rd16(a, r);
      m = {{8{ram_vb[int'(a) % 256][1]}}, {8{ram_vb[int'(a) % 256][0]}}};
      if (m != 16'h0000) begin
        checks++;
        if ((r & m) !== (ram_m[int'(a) % 256] & m)) begin
          fails++; $display("FAIL ram_alias a=%h: got %h want %h mask %h", a, r, ram_m[int'(a) % 256], m);
        end
      end
    end
  endtask

  task automatic test_wait_states();
    logic [15:0] r; int lat; logic oa, oi;
    sel_ws = 1'b1;
    bus_access(1'b0, 23'h000055, 16'hA5C3, 1'b0, 1'b0, r, lat, oa, oi);
    checks++; if (lat !== 7) begin fails++; $display("FAIL ws_write_latency: got %0d want 7", lat); end
    bus_access(1'b1, 23'h000055, 16'h0000, 1'b0, 1'b0, r, lat, oa, oi);
    checks++; if (lat !== 7)       begin fails++; $display("FAIL ws_read_latency: got %0d want 7", lat); end
    checks++; if (r !== 16'hA5C3)  begin fails++; $display("FAIL ws_data: got %h want A5C3", r); end
    checks++; if (oa !== 1'b1)     begin fails++; $display("FAIL ws_oe: got %b want 1", oa); end
    sel_ws = 1'b0;
  endtask

  task automatic test_rx_overrun();
    logic [15:0] r; logic [7:0] b, e;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom); rx_pulse(b);
      if (rxq.size() < 16) rxq.push_back(b); else m_ovr = 1'b1;
    end
    repeat (2) @(negedge clk12);
    checks++; if (irq_n !== 1'b0) begin fails++; $display("FAIL rx_irq: got %b want 0", irq_n); end
    rd16(A_ST, r);
    checks++; if (r !== exp_status()) begin fails++; $display("FAIL rx_ovr_status: got %h want %h", r, exp_status()); end
    m_ovr = 1'b0; m_drop = 1'b0;
    rd16(A_ST, r);
    checks++; if (r !== exp_status()) begin fails++; $display("FAIL rx_ovr_clear: got %h want %h", r, exp_status()); end
    while (rxq.size() > 0) begin
      e = rxq.pop_front();
      rd16(A_RX, r);
      checks++; if (r !== {e, e}) begin fails++; $display("FAIL rx_data: got %h want %h", r, {e, e}); end
    end
    rd16(A_RX, r);
    checks++; if (r !== 16'h0000) begin fails++; $display("FAIL rx_empty_read: got %h want 0000", r); end
    rd16(A_ST, r);
    checks++; if (r !== exp_status()) begin fails++; $display("FAIL rx_empty_status: got %h want %h", r, exp_status()); end
    checks++; if (irq_n !== 1'b1) begin fails++; $display("FAIL rx_irq_clear: got %b want 1", irq_n); end
  endtask

  task automatic test_rx_simultaneous();
    logic [15:0] r; logic [7:0] b, e, nb; int n;
    for (int i = 0; i < 16; i++) begin b = 8'($urandom); rx_pulse(b); rxq.push_back(b); end
    nb = 8'($urandom);
    @(negedge clk12);
    b_addr = A_RX; b_rwn = 1'b1; b_udsn = 1'b0; b_ldsn = 1'b0; b_asn = 1'b0;
    // the pop lands on the 4th edge after ASn falls; present rx_dv on that edge
    repeat (3) @(posedge clk12);
    @(negedge clk12); rx_dv = 1'b1; rx_byte = nb;
    @(posedge clk12);
    @(negedge clk12); rx_dv = 1'b0;
    e = rxq.pop_front(); rxq.push_back(nb);
    checks++; if (obs_dtackn !== 1'b0) begin fails++; $display("FAIL sim_dtack: got %b want 0", obs_dtackn); end
    checks++; if (obs_dout !== {e, e}) begin fails++; $display("FAIL sim_data: got %h want %h", obs_dout, {e, e}); end
    b_asn = 1'b1; b_udsn = 1'b1; b_ldsn = 1'b1;
    n = 0;
    do begin @(posedge clk12); n++; @(negedge clk12); end while (obs_dtackn !== 1'b1 && n < 40);
    checks++; if (obs_dtackn !== 1'b1) begin fails++; $display("FAIL sim_release: got %b want 1", obs_dtackn); end
    rd16(A_ST, r);
    checks++; if (r !== exp_status()) begin fails++; $display("FAIL sim_status: got %h want %h", r, exp_status()); end
    m_ovr = 1'b0; m_drop = 1'b0;
    while (rxq.size() > 0) begin
      e = rxq.pop_front();
      rd16(A_RX, r);
      checks++; if (r !== {e, e}) begin fails++; $display("FAIL sim_drain: got %h want %h", r, {e, e}); end
    end
    rd16(A_ST, r);
    checks++; if (r !== exp_status()) begin fails++; $display("FAIL sim_final_status: got %h want %h", r, exp_status()); end
  endtask

  task automatic test_tx_drain();
    logic [15:0] r; logic [7:0] b;
    tx_active = 1'b1; txlog.delete();
    wr16(A_TX, 16'h4100, 1'b0, 1'b1); txq.push_back(8'h41);
    wr16(A_TX, 16'h0042, 1'b1, 1'b0); txq.push_back(8'h42);
    wr16(A_TX, 16'h4399, 1'b0, 1'b0); txq.push_back(8'h43);
    repeat (10) @(negedge clk12);
    checks++; if (txlog.size() != 0) begin fails++; $display("FAIL tx_hold: got %0d pulses want 0", txlog.size()); end
    run_uart(3);
    checks++; if (txlog.size() != 3) begin fails++; $display("FAIL tx_count: got %0d want 3", txlog.size()); end
    for (int i = 0; i < 3 && i < txlog.size(); i++) begin
      checks++; if (txlog[i] !== txq[i]) begin fails++; $display("FAIL tx_order[%0d]: got %h want %h", i, txlog[i], txq[i]); end
    end
    txq.delete(); txlog.delete();
    checks++; if (tx_bad_active != 0) begin fails++; $display("FAIL tx_while_active: got %0d want 0", tx_bad_active); end
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom); wr16(A_TX, {8'h00, b}, 1'b1, 1'b0);
      if (txq.size() < 16) txq.push_back(b); else m_drop = 1'b1;
    end
    rd16(A_ST, r);
    checks++; if (r !== exp_status()) begin fails++; $display("FAIL tx_drop_status: got %h want %h", r, exp_status()); end
    m_ovr = 1'b0; m_drop = 1'b0;
    rd16(A_ST, r);
    checks++; if (r !== exp_status()) begin fails++; $display("FAIL tx_drop_clear: got %h want %h", r, exp_status()); end
    rd16(A_TX, r);
    checks++; if (r !== 16'h0000) begin fails++; $display("FAIL tx_read: got %h want 0000", r); end
    run_uart(16);
    checks++; if (txlog.size() != 16) begin fails++; $display("FAIL tx_full_count: got %0d want 16", txlog.size()); end
    for (int i = 0; i < 16 && i < txlog.size(); i++) begin
      checks++; if (txlog[i] !== txq[i]) begin fails++; $display("FAIL tx_full_order[%0d]: got %h want %h", i, txlog[i], txq[i]); end
    end
    txq.delete();
    checks++; if (tx_bad_active != 0 || tx_double != 0) begin
      fails++; $display("FAIL tx_pulse_rules: active=%0d double=%0d want 0/0", tx_bad_active, tx_double);
    end
    rd16(A_ST, r);
    checks++; if (r !== exp_status()) begin fails++; $display("FAIL tx_empty_status: got %h want %h", r, exp_status()); end
  endtask

  task automatic test_reserved();
    logic [15:0] r;
    wr16(A_R3, 16'hABCD, 1'b0, 1'b0);
    rd16(A_R3, r);
    checks++; if (r !== 16'h0000) begin fails++; $display("FAIL reg3_read: got %h want 0000", r); end
    wr16(A_RX, 16'h5555, 1'b0, 1'b0);
    rd16(A_ST, r);
    checks++; if (r !== exp_status()) begin fails++; $display("FAIL rx_write_ignored: got %h want %h", r, exp_status()); end
    wr16(A_ST, 16'hFFFF, 1'b0, 1'b0);
    rd16(A_ST, r);
    checks++; if (r !== exp_status()) begin fails++; $display("FAIL status_ro: got %h want %h", r, exp_status()); end
  endtask

  task automatic test_reset_mid_cycle();
    logic [15:0] r; int n;
    wr16(23'h000030, 16'h7E57, 1'b0, 1'b0); model_write(23'h000030, 16'h7E57, 1'b0, 1'b0);
    rx_pulse(8'h11); rx_pulse(8'h22); rxq.push_back(8'h11); rxq.push_back(8'h22);
    @(negedge clk12);
    b_addr = 23'h000030; b_rwn = 1'b1; b_udsn = 1'b0; b_ldsn = 1'b0; b_asn = 1'b0;
    n = 0;
    do begin @(posedge clk12); n++; @(negedge clk12); end while (obs_dtackn !== 1'b0 && n < 40);
    checks++; if (obs_dtackn !== 1'b0) begin fails++; $display("FAIL mid_first_ack: got %b want 0", obs_dtackn); end
    rst = 1'b1;
    @(posedge clk12);
    @(negedge clk12); rst = 1'b0;
    rxq.delete(); txq.delete(); m_ovr = 1'b0; m_drop = 1'b0;
    checks++; if (obs_dtackn !== 1'b1) begin fails++; $display("FAIL mid_dtack_release: got %b want 1", obs_dtackn); end
    checks++; if (obs_oe !== 1'b0)     begin fails++; $display("FAIL mid_oe_release: got %b want 0", obs_oe); end
    checks++; if (irq_n !== 1'b1)      begin fails++; $display("FAIL mid_irq: got %b want 1", irq_n); end
    n = 0;
    do begin @(posedge clk12); n++; @(negedge clk12); end while (obs_dtackn !== 1'b0 && n < 40);
    checks++; if (n !== 4)             begin fails++; $display("FAIL mid_reack_latency: got %0d want 4", n); end
    checks++; if (obs_dout !== ram_m[48]) begin fails++; $display("FAIL mid_ram_kept: got %h want %h", obs_dout, ram_m[48]); end
    b_asn = 1'b1; b_udsn = 1'b1; b_ldsn = 1'b1;
    n = 0;
    do begin @(posedge clk12); n++; @(negedge clk12); end while (obs_dtackn !== 1'b1 && n < 40);
    checks++; if (obs_dtackn !== 1'b1) begin fails++; $display("FAIL mid_final_release: got %b want 1", obs_dtackn); end
    rd16(A_ST, r);
    checks++; if (r !== exp_status()) begin fails++; $display("FAIL mid_fifo_cleared: got %h want %h", r, exp_status()); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ram_m[i] = 16'h0000; ram_vb[i] = 2'b00; end
    test_reset();
    test_zero_wait_read();
    test_byte_lanes();
    test_ram_random();
    test_wait_states();
    test_rx_overrun();
    test_rx_simultaneous();
    test_tx_drain();
    test_reserved();
    test_reset_mid_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/m68k_bus_uart_slave.md
Name: m68k_bus_uart_slave

Overview:
Parametrised 68000 bus target that serves a boot/work RAM and a FIFO-buffered UART register window on the 68000 asynchronous bus. It supports byte-lane writes (UDSn/LDSn), configurable wait states, and RX/TX FIFOs of configurable depth. Overrun and drop flags are sticky. It sits between the 68000 pins/IO cells and the existing UART_TX/UART_RX cores, all in the clk12 domain.

Parameters:
MEM_AW, 12, RAM word-address width; RAM holds 2^MEM_AW 16-bit words, indexed by addr[MEM_AW:1]
WAIT_STATES, 0, extra clk12 cycles inserted before each access (0..15)
FIFO_AW, 4, FIFO address width; each FIFO is 2^FIFO_AW bytes deep
UART_BASE, 23'h03c000, word address of the register window (4 words)
INIT_FILE, "", optional $readmemh image for RAM

Ports:
clk12  in  1  system clock; all logic is on its rising edge
rst  in  1  reset, synchronous and active-high
addr  in  23  68000 address bits [23:1]
data_in  in  16  bus data from the IO cell
data_out  out  16  read data to the IO cell
data_oe  out  1  drive-enable for the IO cell (DIR)
ASn  in  1  address strobe, asynchronous
R_Wn  in  1  1 = read, 0 = write; asynchronous
UDSn  in  1  upper data strobe, asynchronous
LDSn  in  1  lower data strobe, asynchronous
DTACKn  out  1  data transfer acknowledge
tx_dv  out  1  one-cycle start pulse to UART_TX
tx_data  out  8  byte to UART_TX
tx_active  in  1  UART_TX busy
rx_dv  in  1  one-cycle byte-valid from UART_RX
rx_byte  in  8  byte from UART_RX
irq_n  out  1  low while the RX FIFO is non-empty

Behaviour:
- Synchronisers: ASn, R_Wn, UDSn and LDSn each pass through two flops; all four reset to 1. addr and data_in are sampled directly and are stable while synced AS is low.
- Reset values: DTACKn=1, data_oe=0, data_out=0, tx_dv=0, tx_data=0, irq_n=1. FIFOs are emptied and sticky flags cleared. RAM contents are retained.
- Bus FSM states: IDLE, WAIT, ACCESS, ACK.
  - IDLE: when synced AS is low, latch addr, rw and both strobes. Go to WAIT if WAIT_STATES>0, else to ACCESS.
  - WAIT: down-counter loaded with WAIT_STATES-1; go to ACCESS when it reaches 0.
  - ACCESS: exactly one cycle. Performs the read into the data_out register, or the write. Then go to ACK.
  - ACK: DTACKn=0 and data_oe=rw, both registered on entry. Hold until synced AS is high. On that cycle go to IDLE; DTACKn=1 and data_oe=0 take effect on the next edge.
- Latency: DTACKn falls 2+WAIT_STATES cycles after the first cycle IDLE samples synced AS low. data_out is valid no later than DTACKn.
- Write lanes: UDSn low writes [15:8]; LDSn low writes [7:0]. If both strobes are high, nothing is written but the cycle is still acknowledged.
- Decode: any address outside UART_BASE..UART_BASE+3 maps to RAM, which aliases with wrap on addr[MEM_AW:1].
- UART_BASE+0, RX data:
  - Read returns {head,head} and pops if the RX FIFO is non-empty.
  - Read with the RX FIFO empty returns 16'h0000 and does not pop.
  - Writes are ignored.
- UART_BASE+1, TX data:
  - Write pushes data_in[15:8] if UDSn is low, else data_in[7:0].
  - If the TX FIFO is full, the byte is dropped and tx_drop is set.
  - Read returns 0.
- UART_BASE+2, status (read only):
  - {8'h0, rx_overrun, tx_drop, tx_full, rx_empty, rx_count[3:0]}; rx_count saturates at 15.
  - Reading clears rx_overrun and tx_drop. If a set event occurs in the same cycle, set wins.
- UART_BASE+3: reads 16'h0000; writes are ignored.
- RX push: on rx_dv, push rx_byte. If the FIFO is full and no pop occurs that cycle, drop the byte and set rx_overrun. A simultaneous push and pop when full is accepted with no overrun.
- TX drain:
  - When the TX FIFO is non-empty, tx_active=0 and the holdoff counter is 0: pulse tx_dv for one cycle with tx_data=head, then pop.
  - A 2-cycle holdoff follows each pulse before tx_active is sampled again.
- FIFOs: use a count of FIFO_AW+1 bits; pointers wrap modulo depth. A simultaneous push and pop leaves the count unchanged. Popping when empty and pushing when full without a pop never corrupt the pointers.
- irq_n = ~(rx_count!=0), registered.
- Reset mid-cycle: FSM goes to IDLE and DTACKn and data_oe release on the next edge. If ASn is still low after reset, a fresh cycle is decoded and acknowledged.

Test Plan:
- Zero-wait read: preload RAM[0x010]=16'hBEEF, read addr 23'h000010 -> DTACKn low 2 cycles after synced AS; data_out=16'hBEEF; data_oe=1 during ACK, 0 after ASn rises.
- Byte-lane writes: write 16'h1234 with UDSn=0,LDSn=1 over RAM 16'hFFFF -> readback 16'h12FF; write with both strobes high -> data unchanged, DTACKn still asserted.
- WAIT_STATES=3: any read -> DTACKn falls 5 cycles after synced AS.
- RX overrun: 17 rx_dv pulses with FIFO_AW=4 -> status reads rx_count=15 and rx_overrun=1 (16'h008F); a second status read returns 16'h000F.
- Simultaneous RX: with the RX FIFO full, rx_dv in the same cycle as an RX-data read pop -> no overrun, count stays 16.
- TX drain: push 8'h41,8'h42,8'h43 while tx_active=1 -> no tx_dv. Release tx_active -> three tx_dv pulses in order 41,42,43, each only after tx_active drops. A 17th push while full -> tx_drop=1.
